// File: rtl/cipher_share_collector.sv
// Deserialises the bit-serial cipher shares of the threshold SIMON datapath into blocks with a one-deep output buffer.
// Build option COLLECTOR_KEEP_SHARES_EN keeps the two shares apart (out_data = share A, out_data_b = share B).
module cipher_share_collector #(
  parameter int BLOCK_BITS = 128,
  parameter int CNT_W      = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit_valid,
  input  logic                  block_start,
  input  logic                  share_a_bit,
  input  logic                  share_b_bit,
  input  logic                  out_ready,
  input  logic                  clr_overrun,
  output logic                  out_valid,
  output logic [BLOCK_BITS-1:0] out_data,
`ifdef COLLECTOR_KEEP_SHARES_EN
  output logic [BLOCK_BITS-1:0] out_data_b,
`endif
  output logic                  overrun,
  output logic [CNT_W-1:0]      bit_count
);

  // out_valid/out_ready: a block transfers on every edge where both are high. Once raised,
  // out_valid stays high and out_data stays stable until that transfer happens.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BLOCK_BITS-1:0] sr_a_q, sr_a_d, cand_a, data_a_q;
  logic                  overrun_q, overrun_d;
  logic                  lane_a_bit;
  logic                  completion, handshake, load, drop;

`ifdef COLLECTOR_KEEP_SHARES_EN
  logic [BLOCK_BITS-1:0] sr_b_q, sr_b_d, cand_b, data_b_q;
  assign lane_a_bit = share_a_bit;
  assign cand_b     = {share_b_bit, sr_b_q[BLOCK_BITS-1:1]};
  assign sr_b_d     = bit_valid ? cand_b : sr_b_q;
  assign out_data_b = data_b_q;
`else
  assign lane_a_bit = share_a_bit ^ share_b_bit;
`endif

  assign cand_a     = {lane_a_bit, sr_a_q[BLOCK_BITS-1:1]};
  assign sr_a_d     = bit_valid ? cand_a : sr_a_q;
  assign completion = bit_valid & ~block_start & (cnt_q == CNT_W'(BLOCK_BITS - 1));
  assign handshake  = (state_q == FULL) & out_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (block_start)     cnt_d = bit_valid ? CNT_W'(1) : '0;
    else if (completion) cnt_d = '0;
    else if (bit_valid)  cnt_d = cnt_q + CNT_W'(1);
  end

  // Holding-register FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Holding-register FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (completion) state_d = FULL;
      FULL:    if (handshake && !completion) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Holding-register FSM: outputs and load/drop decisions
  always_comb begin
    out_valid = (state_q == FULL);
    load      = completion & ((state_q == EMPTY) | out_ready);
    drop      = completion & (state_q == FULL) & ~out_ready;
    overrun_d = overrun_q;
    if (drop)             overrun_d = 1'b1;
    else if (clr_overrun) overrun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      sr_a_q    <= '0;
      data_a_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      sr_a_q    <= sr_a_d;
      overrun_q <= overrun_d;
      if (load) data_a_q <= cand_a;
    end
  end

`ifdef COLLECTOR_KEEP_SHARES_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_b_q   <= '0;
      data_b_q <= '0;
    end else begin
      sr_b_q <= sr_b_d;
      if (load) data_b_q <= cand_b;
    end
  end
`endif

  assign out_data  = data_a_q;
  assign overrun   = overrun_q;
  assign bit_count = cnt_q;

endmodule

// File: tb/tb_cipher_share_collector.sv
// Bench for cipher_share_collector: directed scenarios plus a randomized run against a word-level model.
module tb_cipher_share_collector;
  localparam int BB = 128;
  localparam logic [BB-1:0] KEY = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [BB-1:0] PATB = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5;

  logic clk = 1'b0;
  logic rst, bit_valid, block_start, share_a_bit, share_b_bit, out_ready, clr_overrun;
  logic out_valid, overrun;
  logic [BB-1:0] out_data;
  logic [6:0] bit_count;
`ifdef COLLECTOR_KEEP_SHARES_EN
  logic [BB-1:0] out_data_b;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  // Word-level model: bits are placed by index into the block being built.
  logic [BB-1:0] m_wa, m_wb, m_da, m_db;
  int m_cnt;
  logic m_valid, m_ovr;

  cipher_share_collector dut (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .block_start(block_start),
    .share_a_bit(share_a_bit), .share_b_bit(share_b_bit), .out_ready(out_ready),
    .clr_overrun(clr_overrun), .out_valid(out_valid), .out_data(out_data),
`ifdef COLLECTOR_KEEP_SHARES_EN
    .out_data_b(out_data_b),
`endif
    .overrun(overrun), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  function automatic logic [BB-1:0] exp_data();
`ifdef COLLECTOR_KEEP_SHARES_EN
    return m_da;
`else
    return m_da ^ m_db;
`endif
  endfunction

  task automatic cycle(input logic r, bv, bs, a, b, rdy, clr);
    logic comp, hs, drop;
    rst = r; bit_valid = bv; block_start = bs; share_a_bit = a; share_b_bit = b;
    out_ready = rdy; clr_overrun = clr;
    @(posedge clk);
    if (r) begin
      m_cnt = 0; m_valid = 1'b0; m_da = '0; m_db = '0; m_ovr = 1'b0;
    end else begin
      comp = bv && !bs && (m_cnt == BB - 1);
      hs = m_valid && rdy;
      if (bs) begin
        m_cnt = bv ? 1 : 0;
        if (bv) begin m_wa[0] = a; m_wb[0] = b; end
      end else if (bv) begin
        m_wa[m_cnt] = a; m_wb[m_cnt] = b;
        m_cnt = (m_cnt + 1) % BB;
      end
      drop = comp && m_valid && !hs;
      if (comp && !drop) begin m_da = m_wa; m_db = m_wb; m_valid = 1'b1; end
      else if (hs && !comp) m_valid = 1'b0;
      if (drop) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
    end
    #1;
  endtask

  task automatic send_block(input logic [BB-1:0] wa, wb, input logic rdy_last);
    for (int i = 0; i < BB; i++)
      cycle(1'b0, 1'b1, 1'b0, wa[i], wb[i], (i == BB - 1) ? rdy_last : 1'b0, 1'b0);
  endtask

  task automatic drain();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", out_valid); end
    tests_run++; if (out_data !== '0) begin tests_failed++; $display("FAIL reset_data got %h want 0", out_data); end
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun got %b want 0", overrun); end
    tests_run++; if (bit_count !== 7'd0) begin tests_failed++; $display("FAIL reset_count got %0d want 0", bit_count); end
  endtask

  task automatic test_basic();
    logic [BB-1:0] wa;
    wa = PATB ^ KEY;
    for (int i = 0; i < BB - 1; i++) cycle(1'b0, 1'b1, 1'b0, wa[i], PATB[i], 1'b0, 1'b0);
    tests_run++; if (out_valid !== 1'b0 || bit_count !== 7'd127) begin tests_failed++; $display("FAIL basic_pre got valid=%b cnt=%0d want 0/127", out_valid, bit_count); end
    cycle(1'b0, 1'b1, 1'b0, wa[BB-1], PATB[BB-1], 1'b0, 1'b0);
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_valid got %b want 1", out_valid); end
`ifdef COLLECTOR_KEEP_SHARES_EN
    tests_run++; if (out_data !== wa || out_data_b !== PATB) begin tests_failed++; $display("FAIL shares_split got %h/%h want %h/%h", out_data, out_data_b, wa, PATB); end
    tests_run++; if ((out_data ^ out_data_b) !== KEY) begin tests_failed++; $display("FAIL shares_xor got %h want %h", out_data ^ out_data_b, KEY); end
`else
    tests_run++; if (out_data !== KEY) begin tests_failed++; $display("FAIL basic_data got %h want %h", out_data, KEY); end
`endif
    tests_run++; if (bit_count !== 7'd0) begin tests_failed++; $display("FAIL basic_count got %0d want 0", bit_count); end
    drain();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_drain got %b want 0", out_valid); end
  endtask

  task automatic test_gapped();
    logic [BB-1:0] wb;
    wb = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++; if (bit_count !== 7'd0) begin tests_failed++; $display("FAIL gap_start_count got %0d want 0", bit_count); end
    for (int i = 0; i < BB; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
      if (out_valid !== 1'b0) begin tests_run++; tests_failed++; $display("FAIL gap_early_valid got 1 want 0 at bit %0d", i); end
      cycle(1'b0, 1'b1, 1'b0, wb[i] ^ (i == 0), wb[i], 1'b0, 1'b0);
    end
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL gap_valid got %b want 1", out_valid); end
`ifndef COLLECTOR_KEEP_SHARES_EN
    tests_run++; if (out_data !== 128'h1) begin tests_failed++; $display("FAIL gap_data got %h want 1", out_data); end
`endif
    drain();
  endtask

  task automatic test_overrun();
    send_block(128'hFF ^ PATB, PATB, 1'b0);
    send_block(128'hFF00 ^ PATB, PATB, 1'b0);
`ifndef COLLECTOR_KEEP_SHARES_EN
    tests_run++; if (out_data !== 128'hFF) begin tests_failed++; $display("FAIL ovr_data got %h want ff", out_data); end
`endif
    tests_run++; if (overrun !== 1'b1 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL ovr_flag got ovr=%b valid=%b want 1/1", overrun, out_valid); end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_clear got %b want 0", overrun); end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [BB-1:0] x, y;
    x = {$urandom, $urandom, $urandom, $urandom};
    y = {$urandom, $urandom, $urandom, $urandom};
    send_block(x, '0, 1'b0);
    send_block(y, '0, 1'b1);
    tests_run++; if (out_valid !== 1'b1 || overrun !== 1'b0) begin tests_failed++; $display("FAIL b2b_flags got valid=%b ovr=%b want 1/0", out_valid, overrun); end
    tests_run++; if (out_data !== y) begin tests_failed++; $display("FAIL b2b_data got %h want %h", out_data, y); end
    drain();
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 70; i++) cycle(1'b0, 1'b1, 1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++; if (out_valid !== 1'b0 || out_data !== '0 || bit_count !== 7'd0) begin tests_failed++; $display("FAIL mid_reset got valid=%b data=%h cnt=%0d want 0/0/0", out_valid, out_data, bit_count); end
    send_block(128'hDEAD_BEEF, '0, 1'b0);
    tests_run++; if (out_valid !== 1'b1 || out_data !== 128'hDEAD_BEEF) begin tests_failed++; $display("FAIL mid_reset_block got valid=%b data=%h want 1/deadbeef", out_valid, out_data); end
    drain();
  endtask

  task automatic test_random();
    for (int n = 0; n < 6000; n++) begin
      cycle(($urandom_range(0, 1999) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 399) == 0),
            1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0));
      tests_run++;
      if (out_valid !== m_valid || out_data !== exp_data() || overrun !== m_ovr || bit_count !== 7'(m_cnt)
`ifdef COLLECTOR_KEEP_SHARES_EN
          || out_data_b !== m_db
`endif
         ) begin
        tests_failed++;
        if (tests_failed < 20)
          $display("FAIL random cyc %0d got v=%b ovr=%b cnt=%0d d=%h want v=%b ovr=%b cnt=%0d d=%h",
                   n, out_valid, overrun, bit_count, out_data, m_valid, m_ovr, m_cnt, exp_data());
      end
    end
  endtask

  initial begin
    m_wa = '0; m_wb = '0;
    test_reset();
    test_basic();
    test_gapped();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/cipher_share_collector.md
Name: cipher_share_collector

Overview:
- Receiving end of the bit-serial cipher output of the 2-share threshold SIMON datapath.
- Samples one bit per enabled cycle from each share's serial output, LSB first.
- Recombines the two shares by XOR, or keeps them separate when the optional feature is enabled.
- Packs the bits into a full block and presents it on a parallel valid/ready interface to the host side, with a one-block holding buffer and overrun detection.

Parameters:
- BLOCK_BITS, 128, number of serial bits per cipher block.
- CNT_W, 7, bit-counter width; must satisfy 2^CNT_W >= BLOCK_BITS.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_valid  input  1  share bits are valid this cycle; tied to the datapath output-phase shift enable.
- block_start  input  1  aligns the collector to a new block; the partial block is discarded.
- share_a_bit  input  1  serial cipher bit from share A.
- share_b_bit  input  1  serial cipher bit from share B.
- out_ready  input  1  consumer accepts out_data this cycle.
- clr_overrun  input  1  clears the sticky overrun flag.
- out_valid  output  1  out_data holds a complete block.
- out_data  output  BLOCK_BITS  assembled block; bit 0 is the first received bit.
- overrun  output  1  sticky flag: a completed block was dropped.
- bit_count  output  CNT_W  number of bits collected in the current block.

Behaviour:
- Reset (rst=1 at a clock edge) clears the following, overriding all other inputs including an in-flight block:
  - out_valid=0, out_data=0, overrun=0.
  - bit_count=0 and the shift register to 0.
- Bit combine: b = share_a_bit ^ share_b_bit (shared mode: see Optional Feature).
- Shift: on an edge with bit_valid=1, sr <= {b, sr[BLOCK_BITS-1:1]} and bit_count increments. The first bit of a block therefore ends in bit 0.
- bit_valid=0: sr and bit_count hold. Gaps of any length are allowed between bits.
- block_start=1, bit_valid=0: bit_count <= 0; the partial block is discarded (sr contents are don't-care).
- block_start=1, bit_valid=1: bit_count <= 1; the current bit becomes bit 0 of the new block.
- Completion event: bit_valid=1, bit_count==BLOCK_BITS-1 and block_start=0.
  - bit_count wraps to 0.
  - The assembled word {b, sr[BLOCK_BITS-1:1]} is the candidate block.
- Output holding register, two states:
  - EMPTY (out_valid=0):
    - On completion: out_data <= candidate, go to FULL.
    - Latency: out_valid is high in the cycle after the edge sampling the final bit.
  - FULL (out_valid=1): out_data is stable until a handshake.
    - Handshake = out_valid & out_ready.
    - Handshake without completion: go to EMPTY; out_data holds its old value.
    - Handshake with completion in the same cycle: out_data <= candidate and stay FULL. No bubble, no overrun.
    - Completion without handshake: candidate dropped, overrun <= 1, out_data unchanged.
- overrun:
  - Sticky; cleared only by rst or clr_overrun.
  - If clr_overrun and a new overrun coincide, set wins.
- out_ready while EMPTY is ignored.
- block_start never affects the holding register.

Optional Feature:
- Macro COLLECTOR_KEEP_SHARES_EN.
- Defined:
  - No XOR recombination.
  - Adds output port out_data_b (BLOCK_BITS). out_data carries share A and out_data_b carries share B.
  - Two parallel shift registers; both load, hold and drop together under identical handshake/overrun rules.
  - out_data_b resets to 0.
  - The unmasked value never exists inside the block.
- Undefined: XOR recombination as above; no out_data_b port.

Test Plan:
- Basic block:
  - Stimulus: share B = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5; share A = B ^ 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210; 128 consecutive bit_valid cycles, LSB first.
  - Response: out_valid=1 exactly one cycle after the 128th bit edge; out_data=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210; bit_count=0.
- Gapped input and block_start:
  - Stimulus: 40 bits, then block_start with bit_valid=0, then 128 bits of pattern 128'h1 with bit_valid toggling every other cycle.
  - Response: out_data=128'h1; the 40-bit partial never appears.
- Back-pressure overrun:
  - Stimulus: out_ready=0; two full blocks X=128'hFF and Y=128'hFF00.
  - Response: out_data stays 128'hFF; overrun=1 after Y's last bit; clr_overrun pulse returns it to 0.
- Same-cycle drain and load:
  - Stimulus: block X valid; out_ready=1 exactly on the edge where block Y completes.
  - Response: out_valid remains 1; out_data=Y next cycle; overrun=0.
- Reset mid-block:
  - Stimulus: rst pulsed after 70 bits of a block; then a full block 128'hDEAD_BEEF.
  - Response: out_valid=0, out_data=0 after reset; subsequent out_data=128'hDEAD_BEEF.
- COLLECTOR_KEEP_SHARES_EN build:
  - Stimulus: the basic-block stimulus.
  - Response: out_data=share A word, out_data_b=share B word; their XOR equals 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210.
